// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg
// Purpose : shared address map, widths, request payload type and I/O decode
//           helper for the CPU-side memory/I/O responder.
// Contents: IO_BASE/IO_UART/IO_CLK map constants, IO_REGION_MSB, RAM_BYTES,
//           mem_req_t request payload, io_sel_e decode result, io_decode().
package mem_io_responder_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DEC_W      = 18;

    localparam logic [BUS_ADDR_W-1:0] IO_BASE       = 32'h0003_0000;
    localparam logic [BUS_ADDR_W-1:0] IO_UART       = IO_BASE;
    localparam logic [BUS_ADDR_W-1:0] IO_CLK        = IO_BASE + 32'd4;
    localparam logic [1:0]            IO_REGION_MSB = 2'b11;
    localparam int unsigned           RAM_BYTES     = 32'h0002_0000;

    // Decoded bus request (only the low DEC_W address bits are meaningful)
    typedef struct packed {
        logic              wr;
        logic [DEC_W-1:0]  addr;
        logic [BYTE_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        SEL_RAM  = 2'd0,
        SEL_UART = 2'd1,
        SEL_CLK  = 2'd2,
        SEL_NONE = 2'd3
    } io_sel_e;

    // Map an address to its target; the whole 0x3xxxx window is I/O
    function automatic io_sel_e io_decode(input logic [DEC_W-1:0] a);
        io_sel_e sel;
        if (a[DEC_W-1:DEC_W-2] != IO_REGION_MSB) begin
            sel = SEL_RAM;
        end else if (a == IO_UART[DEC_W-1:0]) begin
            sel = SEL_UART;
        end else if (a[DEC_W-1:2] == IO_CLK[DEC_W-1:2]) begin
            sel = SEL_CLK;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if
// Purpose : groups the CPU byte bus and the UART TX/RX streams between the
//           responder and its environment.
// Signals : mem_a/mem_wr/mem_wdata/mem_rdata (CPU bus), io_buffer_full,
//           tx_valid/tx_data/tx_ready, rx_valid/rx_data/rx_ready,
//           tx_overflow, sim_stop.
// Modports: slave  - the responder
//           master - CPU + UART side driving requests and stream inputs
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic [BUS_ADDR_W-1:0] mem_a;
    logic                  mem_wr;
    logic [BYTE_W-1:0]     mem_wdata;
    logic [BYTE_W-1:0]     mem_rdata;
    logic                  io_buffer_full;
    logic                  tx_valid;
    logic [BYTE_W-1:0]     tx_data;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [BYTE_W-1:0]     rx_data;
    logic                  rx_ready;
    logic                  tx_overflow;
    logic                  sim_stop;

    modport slave (
        input  mem_a, mem_wr, mem_wdata, tx_ready, rx_valid, rx_data,
        output mem_rdata, io_buffer_full, tx_valid, tx_data, rx_ready,
               tx_overflow, sim_stop
    );

    modport master (
        output mem_a, mem_wr, mem_wdata, tx_ready, rx_valid, rx_data,
        input  mem_rdata, io_buffer_full, tx_valid, tx_data, rx_ready,
               tx_overflow, sim_stop
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo
// Purpose : small synchronous FIFO with extra-MSB pointers, used for the
//           UART TX and RX byte queues.
// Ports   : clk, rst (sync, active-high)
//           i_push/i_din  - write request; accepted when not full, or when a
//                           pop is accepted in the same cycle
//           i_pop         - read request; ignored when empty
//           o_dout        - head entry, forced to 0 when empty
//           o_empty/o_full/o_count - occupancy
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    // Same index with differing wrap bit means the writer lapped the reader
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count   = r_wptr - r_rptr;
    assign o_dout    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage is not reset; occupancy comes from the pointers alone
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
// Purpose : target-side responder for the CPU byte bus. Backs the RAM region
//           and the I/O window at 0x30000+: UART TX/RX queues, the cycle
//           counter with a read snapshot, and the sticky program-stop flag.
// Ports   : clk  - system clock
//           rst  - synchronous active-high reset
//           bus  - mem_io_responder_if.slave (CPU bus + UART streams)
// Config  : MEM_IO_CYCLE_COUNTER_EN - when defined, the 32-bit cycle counter
//           and snapshot exist; otherwise 0x30004..0x30007 read as 0x00.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = $clog2(RAM_BYTES),
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_io_responder_if.slave  bus
);
    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    mem_req_t          w_req;
    io_sel_e           w_sel;
    logic              w_unused_addr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_is_read;

    logic [BYTE_W-1:0] r_ram [2**ADDR_W];
    logic [BYTE_W-1:0] r_rdata;
    logic [BYTE_W-1:0] w_rdata_nxt;
    logic [BYTE_W-1:0] w_clk_byte;
    logic              r_io_full;
    logic              r_tx_ovf;
    logic              r_stop;

    logic                w_tx_push_uart;
    logic                w_tx_push_stop;
    logic                w_tx_push;
    logic                w_tx_push_ok;
    logic                w_tx_pop;
    logic [BYTE_W-1:0]   w_tx_din;
    logic [BYTE_W-1:0]   w_tx_dout;
    logic                w_tx_empty;
    logic                w_tx_full;
    logic [TX_CNT_W-1:0] w_tx_count;
    logic [TX_CNT_W-1:0] w_tx_cnt_nxt;
    logic                w_io_full_nxt;

    logic                w_rx_push;
    logic                w_rx_pop;
    logic [BYTE_W-1:0]   w_rx_dout;
    logic                w_rx_empty;
    logic                w_rx_full;
    logic [RX_CNT_W-1:0] w_rx_count_unused;

    // Request capture and decode; upper address bits are don't-care
    assign w_req         = '{wr: bus.mem_wr, addr: bus.mem_a[DEC_W-1:0], wdata: bus.mem_wdata};
    assign w_sel         = io_decode(w_req.addr);
    assign w_unused_addr = ^bus.mem_a[BUS_ADDR_W-1:DEC_W];
    assign w_ram_addr    = w_req.addr[ADDR_W-1:0];
    assign w_is_read     = !w_req.wr;

    // RAM array; deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (w_req.wr && (w_sel == SEL_RAM)) r_ram[w_ram_addr] <= w_req.wdata;
    end

    // TX queue control: UART data writes of 0x00 are dropped silently,
    // a stop write pushes a 0x00 marker
    assign w_tx_push_uart = w_req.wr && (w_sel == SEL_UART) && (w_req.wdata != 8'h00);
    assign w_tx_push_stop = w_req.wr && (w_sel == SEL_CLK) && (w_req.addr[1:0] == 2'b00);
    assign w_tx_push      = w_tx_push_uart || w_tx_push_stop;
    assign w_tx_din       = w_tx_push_stop ? 8'h00 : w_req.wdata;
    assign w_tx_pop       = !w_tx_empty && bus.tx_ready;
    assign w_tx_push_ok   = w_tx_push && (!w_tx_full || w_tx_pop);
    assign w_tx_cnt_nxt   = w_tx_count + TX_CNT_W'(w_tx_push_ok) - TX_CNT_W'(w_tx_pop);
    assign w_io_full_nxt  = (TX_CNT_W'(TX_DEPTH) - w_tx_cnt_nxt) <= TX_CNT_W'(FULL_MARGIN);

    byte_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (w_tx_din),
        .o_dout  (w_tx_dout),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full),
        .o_count (w_tx_count)
    );

    // RX queue control: CPU pop and UART push may coincide; no bypass
    assign w_rx_push = bus.rx_valid && !w_rx_full;
    assign w_rx_pop  = w_is_read && (w_sel == SEL_UART) && !w_rx_empty;

    byte_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (BYTE_W)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (bus.rx_data),
        .o_dout  (w_rx_dout),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full),
        .o_count (w_rx_count_unused)
    );

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;
    logic [31:8] r_snap;
    logic        w_snap_load;

    // Reading the low byte freezes the upper bytes for the following reads
    assign w_snap_load = w_is_read && (w_sel == SEL_CLK) && (w_req.addr[1:0] == 2'b00);

    // Free-running cycle counter and snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
            r_snap  <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_snap_load) r_snap <= r_cycle[31:8];
        end
    end

    // Byte select within the counter window
    always_comb begin
        w_clk_byte = 8'h00;
        case (w_req.addr[1:0])
            2'b00:   w_clk_byte = r_cycle[7:0];
            2'b01:   w_clk_byte = r_snap[15:8];
            2'b10:   w_clk_byte = r_snap[23:16];
            default: w_clk_byte = r_snap[31:24];
        endcase
    end
`else
    assign w_clk_byte = 8'h00;
`endif

    // Next read byte; writes leave the last read value in place
    always_comb begin
        w_rdata_nxt = r_rdata;
        if (w_is_read) begin
            case (w_sel)
                SEL_RAM:  w_rdata_nxt = r_ram[w_ram_addr];
                SEL_UART: w_rdata_nxt = w_rx_dout;
                SEL_CLK:  w_rdata_nxt = w_clk_byte;
                default:  w_rdata_nxt = 8'h00;
            endcase
        end
    end

    // Registered outputs and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata   <= '0;
            r_io_full <= 1'b0;
            r_tx_ovf  <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_rdata   <= w_rdata_nxt;
            r_io_full <= w_io_full_nxt;
            if (w_tx_push && !w_tx_push_ok) r_tx_ovf <= 1'b1;
            if (w_tx_push_stop)             r_stop   <= 1'b1;
        end
    end

    assign bus.mem_rdata      = r_rdata;
    assign bus.io_buffer_full = r_io_full;
    assign bus.tx_valid       = !w_tx_empty;
    assign bus.tx_data        = w_tx_dout;
    assign bus.rx_ready       = !w_rx_full;
    assign bus.tx_overflow    = r_tx_ovf;
    assign bus.sim_stop       = r_stop;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
// Purpose : self-checking bench for mem_io_responder: table of bus vectors,
//           read-data and TX scoreboards, hand sequences for queue corners,
//           counter snapshot and reset. Honors MEM_IO_CYCLE_COUNTER_EN.
module tb_mem_io_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_io_responder_if bus();

    mem_io_responder #(
        .ADDR_W      (17),
        .TX_DEPTH    (8),
        .RX_DEPTH    (8),
        .FULL_MARGIN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  rd_exp_q [$];
    logic [7:0]  tx_exp_q [$];
    int unsigned tb_cyc;
    vec_t        vecs [13];

    // Cycle reference: zero at the reset edge, +1 per later edge
    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // TX scoreboard: each handshake about to complete is compared in order
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            if (tx_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got 0x%0h expected no byte", bus.tx_data);
            end else begin
                check("tx_data", 32'(bus.tx_data), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle; a checked op queues its expected read byte and
    // compares it once the DUT has registered the response
    task automatic bus_op(input logic wr, input logic [31:0] addr, input logic [7:0] wdata,
                          input logic chk, input logic [7:0] exp, input string name);
        bus.mem_wr    = wr;
        bus.mem_a     = addr;
        bus.mem_wdata = wdata;
        if (chk) rd_exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.mem_wr    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wdata = 8'h00;
        if (chk) check(name, 32'(bus.mem_rdata), 32'(rd_exp_q.pop_front()));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdata"},    32'(bus.mem_rdata),      32'h00);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid),       32'h0);
        check({tag, "_tx_data"},  32'(bus.tx_data),        32'h00);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready),       32'h1);
        check({tag, "_io_full"},  32'(bus.io_buffer_full), 32'h0);
        check({tag, "_tx_ovf"},   32'(bus.tx_overflow),    32'h0);
        check({tag, "_sim_stop"}, 32'(bus.sim_stop),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cval;
        logic [31:0] cexp;

        rst           = 1'b1;
        bus.mem_wr    = 1'b0;
        bus.mem_a     = 32'h0;
        bus.mem_wdata = 8'h00;
        bus.tx_ready  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;

        vecs[0]  = '{1'b1, 32'h0000_1234, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'hA5};
        vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C};
        vecs[4]  = '{1'b1, 32'h0000_0000, 8'h77, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'hA5};
        vecs[6]  = '{1'b1, 32'h0000_1234, 8'h11, 1'b1, 8'hA5};
        vecs[7]  = '{1'b0, 32'h0000_0000, 8'h00, 1'b1, 8'h77};
        vecs[8]  = '{1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h00};
        vecs[9]  = '{1'b1, 32'h0003_0010, 8'h5A, 1'b1, 8'h00};
        vecs[10] = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'h11};
        vecs[12] = '{1'b0, 32'hFFF0_1234, 8'h00, 1'b1, 8'h11};

        idle(3);
        check_reset("reset");
        rst = 1'b0;

        // RAM, misc I/O and empty-RX vectors
        for (int i = 0; i < 13; i++) begin
            bus_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp,
                   $sformatf("vec%0d", i));
        end
        check("no_tx_after_vecs", 32'(bus.tx_valid), 32'h0);

        // TX path with a zero byte that must be skipped
        bus.tx_ready = 1'b1;
        tx_exp_q.push_back(8'h48);
        bus_op(1'b1, 32'h0003_0000, 8'h48, 1'b0, 8'h00, "");
        bus_op(1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, "");
        tx_exp_q.push_back(8'h69);
        bus_op(1'b1, 32'h0003_0000, 8'h69, 1'b0, 8'h00, "");
        idle(5);
        check("tx_path_drained", 32'(tx_exp_q.size()), 32'd0);
        check("tx_path_ovf", 32'(bus.tx_overflow), 32'h0);

        // TX backpressure, overflow, then push into a full queue with a pop
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tx_exp_q.push_back(8'(i));
            bus_op(1'b1, 32'h0003_0000, 8'(i), 1'b0, 8'h00, "");
            if (i == 5) check("io_full_after5", 32'(bus.io_buffer_full), 32'h0);
            if (i == 6) check("io_full_after6", 32'(bus.io_buffer_full), 32'h1);
        end
        check("ovf_after8", 32'(bus.tx_overflow), 32'h0);
        bus_op(1'b1, 32'h0003_0000, 8'h09, 1'b0, 8'h00, "");
        check("ovf_after9", 32'(bus.tx_overflow), 32'h1);
        check("head_after9", 32'(bus.tx_data), 32'h01);
        bus.tx_ready = 1'b1;
        tx_exp_q.push_back(8'h0A);
        bus_op(1'b1, 32'h0003_0000, 8'h0A, 1'b0, 8'h00, "");
        idle(12);
        check("bp_drained", 32'(tx_exp_q.size()), 32'd0);
        check("io_full_drained", 32'(bus.io_buffer_full), 32'h0);

        // RX path
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h31;
        idle(1);
        bus.rx_valid = 1'b0;
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h31, "rx_0x31");
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_empty_after");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_no_bypass");
        bus.rx_valid = 1'b0;
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h55, "rx_after_bypass");
        for (int i = 0; i < 8; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hC0 + 8'(i);
            idle(1);
        end
        check("rx_ready_full", 32'(bus.rx_ready), 32'h0);
        bus.rx_data = 8'hEE;
        idle(1);
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'hC0 + 8'(i), $sformatf("rx_fill%0d", i));
            if (i == 0) check("rx_ready_after_pop", 32'(bus.rx_ready), 32'h1);
        end
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_drop_full");

        // Cycle counter and snapshot
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int g = 0; g < 300 && tb_cyc != 100; g++) idle(1);
        cval = tb_cyc;
`ifdef MEM_IO_CYCLE_COUNTER_EN
        cexp = 32'(cval);
`else
        cexp = 32'h0;
`endif
        bus_op(1'b0, 32'h0003_0004, 8'h00, 1'b1, cexp[7:0],   "clk_b0");
        bus_op(1'b0, 32'h0003_0005, 8'h00, 1'b1, cexp[15:8],  "clk_b1");
        bus_op(1'b0, 32'h0003_0006, 8'h00, 1'b1, cexp[23:16], "clk_b2");
        bus_op(1'b0, 32'h0003_0007, 8'h00, 1'b1, cexp[31:24], "clk_b3");
        idle(3);
        bus_op(1'b0, 32'h0003_0005, 8'h00, 1'b1, cexp[15:8],  "clk_b1_held");
`ifdef MEM_IO_CYCLE_COUNTER_EN
        check("clk_b0_value", 32'(cexp[7:0]), 32'd100);
`endif

        // Program stop
        bus.tx_ready = 1'b1;
        tx_exp_q.push_back(8'h00);
        bus_op(1'b1, 32'h0003_0004, 8'hFF, 1'b0, 8'h00, "");
        check("sim_stop_set", 32'(bus.sim_stop), 32'h1);
        idle(3);
        check("stop_marker_sent", 32'(tx_exp_q.size()), 32'd0);
        check("sim_stop_sticky", 32'(bus.sim_stop), 32'h1);

        // Reset with queued bytes, overflow set and a read outstanding
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) bus_op(1'b1, 32'h0003_0000, 8'h21 + 8'(i), 1'b0, 8'h00, "");
        check("pre_rst_io_full", 32'(bus.io_buffer_full), 32'h1);
        check("pre_rst_ovf", 32'(bus.tx_overflow), 32'h1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        idle(2);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        bus_op(1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'h00, "rst_outstanding_read");
        check_reset("midrst");
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        idle(2);
        bus_op(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00, "rx_lost");
        bus_op(1'b0, 32'h0000_1234, 8'h00, 1'b1, 8'h11, "ram_kept");
        check("tx_empty_after_rst", 32'(bus.tx_valid), 32'h0);
        check("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
